vga_mode_ctrl: RTL and testbench
================================

Name: vga_mode_ctrl

Overview:
- Video-mode controller that sequences the VGA timing generator.
- Holds a 4-entry timing table and drives the generator's twelve timing inputs.
- Services mode-change requests by waiting for a vertical-sync boundary, then holding the generator in reset while the new timing is loaded, then releasing it.
- Sits between the host/switch logic and the timing generator; also drives a pixel-clock select toward the PLL.

Parameters:
- DEFAULT_MODE, 0, mode loaded at reset (0..3).
- HOLD_CYCLES, 16, cycles gen_reset_n is held low per mode load (>=2).
- TIMEOUT_CYCLES, 2000000, cycles to wait for a vsync edge before forcing the load (used only with the optional feature).

Ports:
- clk  in  1  pixel-domain clock.
- reset  in  1  asynchronous, active-high reset.
- mode_req  in  1  single-cycle request strobe.
- mode_sel  in  2  requested mode, sampled when mode_req=1.
- vs_in  in  1  vga_vs from the generator (active-low sync).
- busy  out  1  high while a change is pending or in progress.
- done  out  1  one-cycle pulse when a request completes.
- cur_mode  out  2  mode currently applied.
- pclk_sel  out  2  PLL select; equals cur_mode.
- gen_reset_n  out  1  active-low reset to the generator.
- h_total, h_sync, h_start, h_end  out  12 each  horizontal timing.
- v_total, v_sync, v_start, v_end  out  12 each  vertical timing.
- v_active_14, v_active_24, v_active_34  out  12 each  quarter lines.
- timeout_flag  out  1  sticky; set when a load was forced by timeout.

Behaviour:
- Timing table, listed as h_total/h_sync/h_start/h_end ; v_total/v_sync/v_start/v_end:
  - 0 (640x480): 799/95/141/781 ; 524/1/34/514
  - 1 (800x600): 1055/127/213/1013 ; 627/3/26/626
  - 2 (1024x768): 1343/135/293/1317 ; 805/5/34/802
  - 3 (1280x720): 1649/39/259/1539 ; 749/4/24/744
- Quarter lines are registered at load:
  - q = (v_end - v_start) >> 2, computed as a 12-bit unsigned value.
  - v_active_14 = v_start + q; v_active_24 = v_start + 2q; v_active_34 = v_start + 3q (truncated to 12 bits).
  - Mode 0 gives 154/274/394.
- Reset (asynchronous):
  - State = HOLD, cur_mode = DEFAULT_MODE, all timing outputs = table[DEFAULT_MODE] including quarter values.
  - gen_reset_n = 0, busy = 1, done = 0, timeout_flag = 0, hold counter = 0.
- States:
  - IDLE: busy = 0. On mode_req with mode_sel == cur_mode: done pulses on the next cycle, no reset applied, remain in IDLE. On mode_req with mode_sel != cur_mode: latch pending = mode_sel, busy = 1 next cycle, go to WAIT_VS.
  - WAIT_VS: track vs_in through a 2-flop synchronizer plus an edge register. On a detected falling edge (start of sync, inside blanking) go to LOAD.
  - LOAD: one cycle. gen_reset_n = 0; timing outputs, cur_mode and pclk_sel update from pending (visible the cycle after LOAD); hold counter cleared; go to HOLD.
  - HOLD: gen_reset_n = 0 and the counter increments. When counter == HOLD_CYCLES-1, go to RELEASE.
  - RELEASE: gen_reset_n = 1; done pulses this cycle; busy drops next cycle; go to IDLE.
- Requests that arrive while busy overwrite pending (last wins):
  - In WAIT_VS: the new value is loaded at the same edge.
  - In LOAD/HOLD/RELEASE: the request is queued. After RELEASE the block re-enters WAIT_VS instead of IDLE, busy stays 1, and done still pulses for the completed load.
  - A queued value equal to the newly applied mode is dropped; the block goes to IDLE.
- After reset, HOLD runs HOLD_CYCLES, then RELEASE, with no done pulse.
- Total gen_reset_n low time per load = HOLD_CYCLES + 1 cycles.
- Timing outputs change only in LOAD, never while gen_reset_n = 1.

Optional Feature:
- Macro: VGA_MODE_CTRL_TIMEOUT_EN.
- Defined:
  - WAIT_VS counts cycles. At count TIMEOUT_CYCLES-1 without an edge, go to LOAD and set timeout_flag.
  - timeout_flag clears only on reset.
- Undefined:
  - No counter; WAIT_VS waits indefinitely.
  - timeout_flag is tied to 0.

Test Plan:
- Reset with DEFAULT_MODE=0 -> outputs 799/95/141/781/524/1/34/514, quarters 154/274/394; gen_reset_n low 16 cycles then high; busy falls; no done pulse.
- mode_req with mode_sel=2, then a vs_in falling edge -> LOAD 3 cycles after the edge (synchronizer plus edge register); h_total=1343, v_active_14=226, pclk_sel=2; gen_reset_n low 17 cycles; one done pulse.
- mode_req with mode_sel=0 while cur_mode=0 -> done on the next cycle; gen_reset_n stays 1; busy stays 0.
- mode_req=1 then mode_req=3 during WAIT_VS -> a single load; cur_mode=3, h_total=1649, v_active_34=564.
- mode_req=2 during HOLD of a mode-1 load -> done for mode 1, busy stays 1; at the next edge, a second load to mode 2 with a second done pulse.
- With VGA_MODE_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=100, vs_in held high -> LOAD after 100 cycles in WAIT_VS; timeout_flag=1. Without the macro -> remains in WAIT_VS.

Source files
------------

// File: rtl/vga_mode_ctrl.sv
// Purpose : video-mode sequencer for the VGA timing generator; holds a 4-entry timing table,
//           waits for a vsync boundary, holds the generator in reset while new timing is applied.
// Latency : load begins 3 cycles after a vs_in falling edge; gen_reset_n low HOLD_CYCLES+1 cycles.
// Backpressure: none; requests while busy overwrite the pending mode (last wins), queued past RELEASE.
// Optional: define VGA_MODE_CTRL_TIMEOUT_EN to force the load after TIMEOUT_CYCLES without a vsync edge.
// Ports   : clk/reset (async, active-high); mode_req/mode_sel request; vs_in generator vsync (active low);
//           busy/done/cur_mode/pclk_sel status; gen_reset_n generator reset; h_*/v_*/v_active_* timing;
//           timeout_flag sticky forced-load indicator.
module vga_mode_ctrl #(
    parameter int DEFAULT_MODE   = 0,
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mode_req,
    input  logic [1:0]  mode_sel,
    input  logic        vs_in,
    output logic        busy,
    output logic        done,
    output logic [1:0]  cur_mode,
    output logic [1:0]  pclk_sel,
    output logic        gen_reset_n,
    output logic [11:0] h_total,
    output logic [11:0] h_sync,
    output logic [11:0] h_start,
    output logic [11:0] h_end,
    output logic [11:0] v_total,
    output logic [11:0] v_sync,
    output logic [11:0] v_start,
    output logic [11:0] v_end,
    output logic [11:0] v_active_14,
    output logic [11:0] v_active_24,
    output logic [11:0] v_active_34,
    output logic        timeout_flag
);

    localparam int HW = $clog2(HOLD_CYCLES);

    // Out-of-range parameters stop elaboration rather than producing a silently broken block.
    if (DEFAULT_MODE < 0 || DEFAULT_MODE > 3 || HOLD_CYCLES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("vga_mode_ctrl: parameter out of range");
    end

    typedef struct packed {
        logic [11:0] h_total, h_sync, h_start, h_end;
        logic [11:0] v_total, v_sync, v_start, v_end;
        logic [11:0] va14, va24, va34;
    } timing_t;

    typedef enum logic [2:0] {S_IDLE, S_WAIT_VS, S_LOAD, S_HOLD, S_RELEASE} state_t;

    // Table lookup plus quarter-line derivation; all arithmetic wraps at 12 bits.
    function automatic timing_t mode_timing(input logic [1:0] m);
        timing_t     t;
        logic [11:0] q;
        t = '0;
        case (m)
            2'd0: begin
                t.h_total = 12'd799;  t.h_sync = 12'd95;  t.h_start = 12'd141; t.h_end = 12'd781;
                t.v_total = 12'd524;  t.v_sync = 12'd1;   t.v_start = 12'd34;  t.v_end = 12'd514;
            end
            2'd1: begin
                t.h_total = 12'd1055; t.h_sync = 12'd127; t.h_start = 12'd213; t.h_end = 12'd1013;
                t.v_total = 12'd627;  t.v_sync = 12'd3;   t.v_start = 12'd26;  t.v_end = 12'd626;
            end
            2'd2: begin
                t.h_total = 12'd1343; t.h_sync = 12'd135; t.h_start = 12'd293; t.h_end = 12'd1317;
                t.v_total = 12'd805;  t.v_sync = 12'd5;   t.v_start = 12'd34;  t.v_end = 12'd802;
            end
            default: begin
                t.h_total = 12'd1649; t.h_sync = 12'd39;  t.h_start = 12'd259; t.h_end = 12'd1539;
                t.v_total = 12'd749;  t.v_sync = 12'd4;   t.v_start = 12'd24;  t.v_end = 12'd744;
            end
        endcase
        q      = (t.v_end - t.v_start) >> 2;
        t.va14 = t.v_start + q;
        t.va24 = t.v_start + (q << 1);
        t.va34 = t.v_start + q + (q << 1);
        return t;
    endfunction

    state_t          state, state_nxt;
    timing_t         tim;
    logic [1:0]      pending, pend_nxt;
    logic            queued, queued_nxt;
    logic [HW-1:0]   hold_cnt, hold_nxt;
    logic            ack_q, ack_nxt;
    logic            boot, boot_nxt;      // set until the reset-time load has been released
    logic            load_en;
    logic            req_v;
    logic [1:0]      req_m;
    logic            vs_s1, vs_s2, vs_d;
    logic            vs_fall;

`ifdef VGA_MODE_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]   to_cnt, to_cnt_nxt;
    logic            to_flag, to_flag_nxt;
`endif

    // vsync is asynchronous to clk: two-flop synchronizer plus an edge register.
    assign vs_fall = vs_d & ~vs_s2;

    always_comb begin
        state_nxt  = state;
        pend_nxt   = pending;
        queued_nxt = queued;
        hold_nxt   = hold_cnt;
        ack_nxt    = 1'b0;
        boot_nxt   = boot;
        load_en    = 1'b0;
        req_v      = 1'b0;
        req_m      = pending;
`ifdef VGA_MODE_CTRL_TIMEOUT_EN
        to_cnt_nxt  = to_cnt;
        to_flag_nxt = to_flag;
`endif
        case (state)
            S_IDLE: begin
                if (mode_req) begin
                    if (mode_sel == cur_mode) begin
                        ack_nxt = 1'b1;
                    end else begin
                        pend_nxt  = mode_sel;
                        state_nxt = S_WAIT_VS;
`ifdef VGA_MODE_CTRL_TIMEOUT_EN
                        to_cnt_nxt = '0;
`endif
                    end
                end
            end
            S_WAIT_VS: begin
                if (mode_req) pend_nxt = mode_sel;
`ifdef VGA_MODE_CTRL_TIMEOUT_EN
                to_cnt_nxt = to_cnt + TW'(1);
                if (vs_fall) begin
                    state_nxt = S_LOAD;
                end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt   = S_LOAD;
                    to_flag_nxt = 1'b1;
                end
`else
                if (vs_fall) state_nxt = S_LOAD;
`endif
            end
            S_LOAD: begin
                load_en  = 1'b1;
                hold_nxt = '0;
                if (mode_req) begin
                    pend_nxt   = mode_sel;
                    queued_nxt = 1'b1;
                end
                state_nxt = S_HOLD;
            end
            S_HOLD: begin
                hold_nxt = hold_cnt + HW'(1);
                if (mode_req) begin
                    pend_nxt   = mode_sel;
                    queued_nxt = 1'b1;
                end
                if (hold_cnt == HW'(HOLD_CYCLES - 1)) state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                boot_nxt   = 1'b0;
                queued_nxt = 1'b0;
                // A request landing in this very cycle counts as queued.
                if (mode_req) begin
                    req_v = 1'b1;
                    req_m = mode_sel;
                end else begin
                    req_v = queued;
                    req_m = pending;
                end
                // cur_mode already holds the just-applied mode here.
                if (req_v && req_m != cur_mode) begin
                    pend_nxt  = req_m;
                    state_nxt = S_WAIT_VS;
`ifdef VGA_MODE_CTRL_TIMEOUT_EN
                    to_cnt_nxt = '0;
`endif
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_HOLD;
            tim      <= mode_timing(2'(DEFAULT_MODE));
            cur_mode <= 2'(DEFAULT_MODE);
            pending  <= 2'(DEFAULT_MODE);
            queued   <= 1'b0;
            hold_cnt <= '0;
            ack_q    <= 1'b0;
            boot     <= 1'b1;
            vs_s1    <= 1'b1;
            vs_s2    <= 1'b1;
            vs_d     <= 1'b1;
        end else begin
            state    <= state_nxt;
            pending  <= pend_nxt;
            queued   <= queued_nxt;
            hold_cnt <= hold_nxt;
            ack_q    <= ack_nxt;
            boot     <= boot_nxt;
            vs_s1    <= vs_in;
            vs_s2    <= vs_s1;
            vs_d     <= vs_s2;
            if (load_en) begin
                tim      <= mode_timing(pending);
                cur_mode <= pending;
            end
        end
    end

`ifdef VGA_MODE_CTRL_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt  <= '0;
            to_flag <= 1'b0;
        end else begin
            to_cnt  <= to_cnt_nxt;
            to_flag <= to_flag_nxt;
        end
    end
    assign timeout_flag = to_flag;
`else
    assign timeout_flag = 1'b0;
`endif

    assign busy        = (state != S_IDLE);
    assign gen_reset_n = !(state == S_LOAD || state == S_HOLD);
    assign done        = ack_q | (state == S_RELEASE && !boot);
    assign pclk_sel    = cur_mode;

    assign h_total     = tim.h_total;
    assign h_sync      = tim.h_sync;
    assign h_start     = tim.h_start;
    assign h_end       = tim.h_end;
    assign v_total     = tim.v_total;
    assign v_sync      = tim.v_sync;
    assign v_start     = tim.v_start;
    assign v_end       = tim.v_end;
    assign v_active_14 = tim.va14;
    assign v_active_24 = tim.va24;
    assign v_active_34 = tim.va34;

endmodule

// File: tb/tb_vga_mode_ctrl.sv
module tb_vga_mode_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mode_req = 1'b0;
    logic [1:0]  mode_sel = 2'd0;
    logic        vs_in = 1'b1;
    logic        busy, done, gen_reset_n, timeout_flag;
    logic [1:0]  cur_mode, pclk_sel;
    logic [11:0] h_total, h_sync, h_start, h_end, v_total, v_sync, v_start, v_end;
    logic [11:0] v_active_14, v_active_24, v_active_34;

    int n_cmp = 0;
    int n_err = 0;
    int model_mode = 0;

    vga_mode_ctrl #(.DEFAULT_MODE(0), .HOLD_CYCLES(16), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .reset(reset), .mode_req(mode_req), .mode_sel(mode_sel), .vs_in(vs_in),
        .busy(busy), .done(done), .cur_mode(cur_mode), .pclk_sel(pclk_sel),
        .gen_reset_n(gen_reset_n),
        .h_total(h_total), .h_sync(h_sync), .h_start(h_start), .h_end(h_end),
        .v_total(v_total), .v_sync(v_sync), .v_start(v_start), .v_end(v_end),
        .v_active_14(v_active_14), .v_active_24(v_active_24), .v_active_34(v_active_34),
        .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    // Reference timing: raw table rows, quarters derived with plain integer arithmetic.
    function automatic void model_timing(input int m, output int e[11]);
        int tab[4][8];
        int q;
        tab[0] = '{799, 95, 141, 781, 524, 1, 34, 514};
        tab[1] = '{1055, 127, 213, 1013, 627, 3, 26, 626};
        tab[2] = '{1343, 135, 293, 1317, 805, 5, 34, 802};
        tab[3] = '{1649, 39, 259, 1539, 749, 4, 24, 744};
        for (int i = 0; i < 8; i++) e[i] = tab[m][i];
        q     = ((tab[m][7] - tab[m][6]) % 4096) / 4;
        e[8]  = (tab[m][6] + q) % 4096;
        e[9]  = (tab[m][6] + 2 * q) % 4096;
        e[10] = (tab[m][6] + 3 * q) % 4096;
    endfunction

    function automatic void dut_timing(output int a[11]);
        a = '{int'(h_total), int'(h_sync), int'(h_start), int'(h_end), int'(v_total), int'(v_sync),
              int'(v_start), int'(v_end), int'(v_active_14), int'(v_active_24), int'(v_active_34)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [1:0] m);
        mode_req = 1'b1;
        mode_sel = m;
        tick();
        mode_req = 1'b0;
    endtask

    // Drive a vsync falling edge and follow the resulting reset window up to the RELEASE sample.
    // Optionally issues a request after req_at low cycles.
    task automatic do_load(input int req_at, input logic [1:0] req_sel,
                           output int lat, output int len, output int dn);
        lat = 0; len = 0; dn = 0;
        vs_in = 1'b0;
        while (gen_reset_n === 1'b1 && lat < 50) begin
            if (done === 1'b1) dn++;
            tick();
            lat++;
        end
        vs_in = 1'b1;
        while (gen_reset_n === 1'b0 && len < 100) begin
            if (done === 1'b1) dn++;
            if (len == req_at) begin
                mode_req = 1'b1;
                mode_sel = req_sel;
            end
            tick();
            mode_req = 1'b0;
            len++;
        end
        if (done === 1'b1) dn++;
    endtask

    task automatic test_reset();
        int e[11], a[11];
        int len, dn;
        string nm[11] = '{"h_total", "h_sync", "h_start", "h_end", "v_total", "v_sync",
                          "v_start", "v_end", "v_active_14", "v_active_24", "v_active_34"};
        reset = 1'b1;
        repeat (3) tick();
        model_timing(0, e);
        dut_timing(a);
        for (int i = 0; i < 11; i++) begin
            n_cmp++;
            if (a[i] !== e[i]) begin n_err++; $display("FAIL reset_%s got %0d exp %0d", nm[i], a[i], e[i]); end
        end
        n_cmp++;
        if ({gen_reset_n, busy, done, timeout_flag, cur_mode, pclk_sel} !== 8'b0100_0000) begin
            n_err++;
            $display("FAIL reset_ctrl got gen_reset_n=%b busy=%b done=%b tf=%b cur=%0d pclk=%0d exp 0 1 0 0 0 0",
                     gen_reset_n, busy, done, timeout_flag, cur_mode, pclk_sel);
        end
        reset = 1'b0;
        len = 0; dn = 0;
        while (gen_reset_n === 1'b0 && len < 100) begin
            if (done === 1'b1) dn++;
            tick();
            len++;
        end
        if (done === 1'b1) dn++;
        n_cmp++;
        if (len !== 16) begin n_err++; $display("FAIL reset_low_len got %0d exp 16", len); end
        n_cmp++;
        if (dn !== 0) begin n_err++; $display("FAIL reset_no_done got %0d pulses exp 0", dn); end
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy_fall got %b exp 0", busy); end
        model_mode = 0;
    endtask

    task automatic test_mode_change();
        int lat, len, dn;
        req(2'd2);
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_err++; $display("FAIL chg_busy got busy=%b done=%b exp 1 0", busy, done);
        end
        repeat (4) tick();
        n_cmp++;
        if (gen_reset_n !== 1'b1 || busy !== 1'b1) begin
            n_err++; $display("FAIL chg_wait got gen_reset_n=%b busy=%b exp 1 1", gen_reset_n, busy);
        end
        do_load(-1, 2'd0, lat, len, dn);
        n_cmp++;
        if (lat !== 3) begin n_err++; $display("FAIL chg_latency got %0d exp 3", lat); end
        n_cmp++;
        if (len !== 17) begin n_err++; $display("FAIL chg_low_len got %0d exp 17", len); end
        n_cmp++;
        if (dn !== 1) begin n_err++; $display("FAIL chg_done got %0d exp 1", dn); end
        n_cmp++;
        if (h_total !== 12'd1343 || v_active_14 !== 12'd226 || pclk_sel !== 2'd2 || cur_mode !== 2'd2) begin
            n_err++;
            $display("FAIL chg_values got h_total=%0d va14=%0d pclk=%0d cur=%0d exp 1343 226 2 2",
                     h_total, v_active_14, pclk_sel, cur_mode);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL chg_idle got busy=%b done=%b exp 0 0", busy, done);
        end
        model_mode = 2;
    endtask

    task automatic test_same_mode();
        req(2'(model_mode));
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || gen_reset_n !== 1'b1) begin
            n_err++;
            $display("FAIL same_ack got done=%b busy=%b gen_reset_n=%b exp 1 0 1", done, busy, gen_reset_n);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL same_after got done=%b busy=%b exp 0 0", done, busy);
        end
    endtask

    task automatic test_overwrite();
        int lat, len, dn, lows;
        req(2'd1);
        repeat (2) tick();
        req(2'd3);
        do_load(-1, 2'd0, lat, len, dn);
        n_cmp++;
        if (lat !== 3 || len !== 17 || dn !== 1) begin
            n_err++; $display("FAIL ovw_load got lat=%0d len=%0d done=%0d exp 3 17 1", lat, len, dn);
        end
        n_cmp++;
        if (cur_mode !== 2'd3 || h_total !== 12'd1649 || v_active_34 !== 12'd564) begin
            n_err++;
            $display("FAIL ovw_values got cur=%0d h_total=%0d va34=%0d exp 3 1649 564",
                     cur_mode, h_total, v_active_34);
        end
        tick();
        lows = 0;
        vs_in = 1'b0;
        repeat (6) begin tick(); if (gen_reset_n !== 1'b1 || busy !== 1'b0) lows++; end
        vs_in = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (lows !== 0) begin n_err++; $display("FAIL ovw_single_load got %0d active cycles exp 0", lows); end
        model_mode = 3;
    endtask

    task automatic test_back_to_back();
        int lat, len, dn;
        req(2'd1);
        tick();
        do_load(5, 2'd2, lat, len, dn);
        n_cmp++;
        if (len !== 17 || dn !== 1 || cur_mode !== 2'd1) begin
            n_err++; $display("FAIL b2b_first got len=%0d done=%0d cur=%0d exp 17 1 1", len, dn, cur_mode);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0 || gen_reset_n !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_requeue got busy=%b done=%b gen_reset_n=%b exp 1 0 1", busy, done, gen_reset_n);
        end
        repeat (2) tick();
        do_load(-1, 2'd0, lat, len, dn);
        n_cmp++;
        if (lat !== 3 || len !== 17 || dn !== 1 || cur_mode !== 2'd2 || h_total !== 12'd1343) begin
            n_err++;
            $display("FAIL b2b_second got lat=%0d len=%0d done=%0d cur=%0d h_total=%0d exp 3 17 1 2 1343",
                     lat, len, dn, cur_mode, h_total);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle got busy=%b exp 0", busy); end
        model_mode = 2;
    endtask

    task automatic test_random();
        int e[11], a[11];
        int m, lat, len, dn;
        for (int it = 0; it < 20; it++) begin
            m = $urandom_range(3, 0);
            if (m == model_mode) begin
                req(2'(m));
                n_cmp++;
                if (done !== 1'b1 || busy !== 1'b0) begin
                    n_err++; $display("FAIL rnd_same it=%0d got done=%b busy=%b exp 1 0", it, done, busy);
                end
                tick();
            end else begin
                req(2'(m));
                repeat ($urandom_range(4, 0)) tick();
                if ($urandom_range(1, 0) == 1) begin
                    m = $urandom_range(3, 0);
                    req(2'(m));
                end
                do_load(-1, 2'd0, lat, len, dn);
                n_cmp++;
                if (lat !== 3 || len !== 17 || dn !== 1) begin
                    n_err++;
                    $display("FAIL rnd_load it=%0d got lat=%0d len=%0d done=%0d exp 3 17 1", it, lat, len, dn);
                end
                n_cmp++;
                if (cur_mode !== 2'(m) || pclk_sel !== 2'(m)) begin
                    n_err++;
                    $display("FAIL rnd_mode it=%0d got cur=%0d pclk=%0d exp %0d", it, cur_mode, pclk_sel, m);
                end
                model_timing(m, e);
                dut_timing(a);
                for (int i = 0; i < 11; i++) begin
                    n_cmp++;
                    if (a[i] !== e[i]) begin
                        n_err++; $display("FAIL rnd_timing it=%0d field=%0d got %0d exp %0d", it, i, a[i], e[i]);
                    end
                end
                tick();
                n_cmp++;
                if (busy !== 1'b0) begin n_err++; $display("FAIL rnd_idle it=%0d got busy=%b exp 0", it, busy); end
                model_mode = m;
            end
        end
    endtask

    task automatic test_timeout();
        int m, lat, len, dn;
        m = model_mode ^ 1;
        req(2'(m));
`ifdef VGA_MODE_CTRL_TIMEOUT_EN
        lat = 0;
        while (gen_reset_n === 1'b1 && lat < 300) begin tick(); lat++; end
        n_cmp++;
        if (lat !== 100) begin n_err++; $display("FAIL to_latency got %0d exp 100", lat); end
        len = 0;
        while (gen_reset_n === 1'b0 && len < 100) begin tick(); len++; end
        n_cmp++;
        if (timeout_flag !== 1'b1 || cur_mode !== 2'(m)) begin
            n_err++; $display("FAIL to_flag got flag=%b cur=%0d exp 1 %0d", timeout_flag, cur_mode, m);
        end
        tick();
        dn = 0;
`else
        dn = 0;
        repeat (300) begin
            tick();
            if (gen_reset_n !== 1'b1 || busy !== 1'b1 || timeout_flag !== 1'b0) dn++;
        end
        n_cmp++;
        if (dn !== 0) begin n_err++; $display("FAIL no_timeout got %0d bad cycles exp 0", dn); end
        do_load(-1, 2'd0, lat, len, dn);
        n_cmp++;
        if (lat !== 3 || cur_mode !== 2'(m) || timeout_flag !== 1'b0) begin
            n_err++;
            $display("FAIL no_timeout_load got lat=%0d cur=%0d flag=%b exp 3 %0d 0", lat, cur_mode, timeout_flag, m);
        end
        tick();
`endif
        model_mode = m;
    endtask

    initial begin
        test_reset();
        test_mode_change();
        test_same_mode();
        test_overwrite();
        test_back_to_back();
        test_random();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
